// File: rtl/toggle_counter_pkg.sv
// Shared constants and helpers for the toggle_counter slice.
// Optional build macro: TOGGLE_COUNTER_GRAY_EN (adds the registered gray output).
package toggle_counter_pkg;

    // Boundary behaviour selected by the SATURATE parameter
    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // Encoding of the up_down input
    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

    // Loads above the highest count are clamped so the counter never leaves its modulus
    function automatic logic [31:0] clamp_load(input logic [31:0] value, input logic [31:0] max);
        return (value > max) ? max : value;
    endfunction

endpackage

// File: rtl/toggle_counter_tff.sv
// Single toggle flip-flop cell with true and complemented outputs.
// Both outputs are stored, so q_n never depends combinationally on q.
module tff_cell (
    input  logic clock,
    input  logic reset,
    input  logic toggle,
    input  logic sync_set_val,
    input  logic sync_set,
    output logic q,
    output logic q_n
);

    // Async reset to 0/1; a synchronous set wins over a toggle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q   <= 1'b0;
            q_n <= 1'b1;
        end else if (sync_set) begin
            q   <= sync_set_val;
            q_n <= ~sync_set_val;
        end else if (toggle) begin
            q   <= ~q;
            q_n <= ~q_n;
        end
    end

endmodule

// File: rtl/toggle_counter.sv
// WIDTH-bit up/down counter assembled from tff_cell instances.
// Ordinary steps use the ripple toggle mask; clear, load and the modulus
// boundaries (wrap or saturate) force the cells through their sync_set path.
// Optional build macro: TOGGLE_COUNTER_GRAY_EN adds a registered Gray output.
module toggle_counter
    import toggle_counter_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MAX_COUNT = 2**WIDTH - 1,
    parameter int SATURATE  = MODE_WRAP
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_down,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_n,
    output logic             terminal,
    output logic             at_max,
    output logic             at_zero
`ifdef TOGGLE_COUNTER_GRAY_EN
    ,
    output logic [WIDTH-1:0] gray
`endif
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);

    logic             hit_boundary;
    logic             step_normal;
    logic             set_all;
    logic [WIDTH-1:0] set_val;
    logic [WIDTH-1:0] toggle;
    logic             sat_held;

    assign at_max  = (count == MAX_V);
    assign at_zero = (count == '0);

    // A step is "at the boundary" when it would leave 0..MAX_COUNT
    assign hit_boundary = (up_down == DIR_UP) ? at_max : at_zero;
    assign step_normal  = enable & ~clear & ~load & ~hit_boundary;
    assign set_all      = clear | load | (enable & hit_boundary);

    // Forced value for the cells: clear > load > boundary wrap/hold
    always_comb begin
        set_val = count;
        if (clear)
            set_val = '0;
        else if (load)
            set_val = WIDTH'(clamp_load(32'(load_value), 32'(MAX_COUNT)));
        else if (SATURATE == MODE_SAT)
            set_val = count;
        else if (up_down == DIR_UP)
            set_val = '0;
        else
            set_val = MAX_V;
    end

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            if (i == 0) begin : g_lsb
                assign toggle[i] = step_normal;
            end else begin : g_upper
                assign toggle[i] = step_normal &
                    ((up_down == DIR_UP) ? (&count[i-1:0]) : ~(|count[i-1:0]));
            end

            tff_cell u_cell (
                .clock        (clock),
                .reset        (reset),
                .toggle       (toggle[i]),
                .sync_set_val (set_val[i]),
                .sync_set     (set_all),
                .q            (count[i]),
                .q_n          (count_n[i])
            );
        end
    endgenerate

    // Terminal pulse; in saturate mode sat_held suppresses repeats while parked at a boundary
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            terminal <= 1'b0;
            sat_held <= 1'b0;
        end else if (clear || load) begin
            terminal <= 1'b0;
            sat_held <= 1'b0;
        end else if (enable) begin
            if (hit_boundary) begin
                terminal <= (SATURATE == MODE_SAT) ? ~sat_held : 1'b1;
                sat_held <= 1'b1;
            end else begin
                terminal <= 1'b0;
                sat_held <= 1'b0;
            end
        end else begin
            terminal <= 1'b0;
        end
    end

`ifdef TOGGLE_COUNTER_GRAY_EN
    logic [WIDTH-1:0] next_count;

    assign next_count = set_all ? set_val : (count ^ toggle);

    // Gray code of the value the cells take on this edge
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            gray <= '0;
        else
            gray <= next_count ^ (next_count >> 1);
    end
`endif

endmodule

// File: tb/tb_toggle_counter.sv
// Scoreboard bench for toggle_counter: three instances (full modulus wrap,
// MAX_COUNT=9 wrap, MAX_COUNT=9 saturate) share one stimulus stream.
module tb_toggle_counter;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       up_down = 1'b0;
    logic       clear = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_value = 4'd0;

    logic [3:0] cnt_o  [3];
    logic [3:0] cntn_o [3];
    logic       term_o [3];
    logic       amax_o [3];
    logic       azero_o[3];
`ifdef TOGGLE_COUNTER_GRAY_EN
    logic [3:0] gray_o [3];
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    toggle_counter #(.WIDTH(4)) dut_full (
        .clock(clock), .reset(reset), .enable(enable), .up_down(up_down),
        .clear(clear), .load(load), .load_value(load_value),
        .count(cnt_o[0]), .count_n(cntn_o[0]), .terminal(term_o[0]),
        .at_max(amax_o[0]), .at_zero(azero_o[0])
`ifdef TOGGLE_COUNTER_GRAY_EN
        , .gray(gray_o[0])
`endif
    );

    toggle_counter #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(0)) dut_wrap (
        .clock(clock), .reset(reset), .enable(enable), .up_down(up_down),
        .clear(clear), .load(load), .load_value(load_value),
        .count(cnt_o[1]), .count_n(cntn_o[1]), .terminal(term_o[1]),
        .at_max(amax_o[1]), .at_zero(azero_o[1])
`ifdef TOGGLE_COUNTER_GRAY_EN
        , .gray(gray_o[1])
`endif
    );

    toggle_counter #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1)) dut_sat (
        .clock(clock), .reset(reset), .enable(enable), .up_down(up_down),
        .clear(clear), .load(load), .load_value(load_value),
        .count(cnt_o[2]), .count_n(cntn_o[2]), .terminal(term_o[2]),
        .at_max(amax_o[2]), .at_zero(azero_o[2])
`ifdef TOGGLE_COUNTER_GRAY_EN
        , .gray(gray_o[2])
`endif
    );

    typedef struct packed {
        logic [3:0] c0, c1, c2;
        logic       t0, t1, t2;
    } exp_t;

    exp_t sb[$];

    // Reference model: plain integer counts plus a "parked at boundary" flag
    int mcnt [3];
    bit mheld[3];
    int maxv [3] = '{15, 9, 9};
    bit satv [3] = '{1'b0, 1'b0, 1'b1};

    task automatic check(input string name, input int i, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s dut%0d at %0t: actual %0d required %0d", name, i, $time, act, exp);
        end
    endtask

    task automatic check_outputs(input int i, input int cnt, input bit term);
        check("count",    i, int'(cnt_o[i]),   cnt);
        check("count_n",  i, int'(cntn_o[i]),  (~cnt) & 15);
        check("terminal", i, int'(term_o[i]),  int'(term));
        check("at_max",   i, int'(amax_o[i]),  int'(cnt == maxv[i]));
        check("at_zero",  i, int'(azero_o[i]), int'(cnt == 0));
`ifdef TOGGLE_COUNTER_GRAY_EN
        check("gray",     i, int'(gray_o[i]),  cnt ^ (cnt >> 1));
`endif
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mcnt[i]  = 0;
            mheld[i] = 1'b0;
        end
    endtask

    task automatic model_step(input int i, input bit c, input bit l, input bit e,
                              input bit u, input int lv, output bit term);
        term = 1'b0;
        if (c) begin
            mcnt[i] = 0;
            mheld[i] = 1'b0;
        end else if (l) begin
            mcnt[i] = (lv > maxv[i]) ? maxv[i] : lv;
            mheld[i] = 1'b0;
        end else if (e) begin
            if ((u && mcnt[i] == maxv[i]) || (!u && mcnt[i] == 0)) begin
                if (!satv[i]) begin
                    mcnt[i] = u ? 0 : maxv[i];
                    term = 1'b1;
                end else begin
                    term = !mheld[i];
                    mheld[i] = 1'b1;
                end
            end else begin
                mcnt[i] = u ? mcnt[i] + 1 : mcnt[i] - 1;
                mheld[i] = 1'b0;
            end
        end
    endtask

    // Drive one cycle of inputs and queue the response expected after the next edge
    task automatic cycle(input bit c, input bit l, input bit e, input bit u, input logic [3:0] lv);
        exp_t x;
        bit   t[3];
        @(negedge clock);
        clear      = c;
        load       = l;
        enable     = e;
        up_down    = u;
        load_value = lv;
        for (int i = 0; i < 3; i++)
            model_step(i, c, l, e, u, int'(lv), t[i]);
        x.c0 = 4'(mcnt[0]);
        x.c1 = 4'(mcnt[1]);
        x.c2 = 4'(mcnt[2]);
        x.t0 = t[0];
        x.t1 = t[1];
        x.t2 = t[2];
        sb.push_back(x);
    endtask

    // Monitor: compare every queued expectation just after the edge it refers to
    always begin
        exp_t x;
        @(posedge clock);
        #1;
        if (sb.size() != 0) begin
            x = sb.pop_front();
            check_outputs(0, int'(x.c0), x.t0);
            check_outputs(1, int'(x.c1), x.t1);
            check_outputs(2, int'(x.c2), x.t2);
        end
    end

    initial begin
        model_reset();
        #1 reset = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) check_outputs(i, 0, 1'b0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Count to 7, then reset asynchronously between edges
        for (int k = 0; k < 7; k++) cycle(0, 0, 1, 1, 4'd0);
        @(negedge clock);
        clear = 0; load = 0; enable = 1; up_down = 1;
        #1 reset = 1'b1;
        model_reset();
        #1;
        for (int i = 0; i < 3; i++) check_outputs(i, 0, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        enable = 0;

        // Up wrap over ten steps
        for (int k = 0; k < 10; k++) cycle(0, 0, 1, 1, 4'd0);
        // Down wrap from 0, then an ordinary down step
        cycle(1, 0, 0, 0, 4'd0);
        cycle(0, 1, 0, 0, 4'd0);
        cycle(0, 0, 1, 0, 4'd0);
        cycle(0, 0, 1, 0, 4'd0);
        // Priority, then clamped load
        cycle(1, 1, 1, 1, 4'd5);
        cycle(0, 1, 0, 0, 4'd14);
        // Twelve up steps from 0 (saturation on the MAX_COUNT=9 instance)
        cycle(1, 0, 0, 0, 4'd0);
        for (int k = 0; k < 12; k++) cycle(0, 0, 1, 1, 4'd0);
        // Full 16-step sweep for the Gray sequence including 15 -> 0
        cycle(1, 0, 0, 0, 4'd0);
        for (int k = 0; k < 17; k++) cycle(0, 0, 1, 1, 4'd0);
        // Saturate at zero while counting down
        cycle(1, 0, 0, 0, 4'd0);
        for (int k = 0; k < 3; k++) cycle(0, 0, 1, 0, 4'd0);

        // Randomised traffic
        for (int k = 0; k < 400; k++)
            cycle($urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)));

        @(negedge clock);
        clear = 0; load = 0; enable = 0;
        repeat (4) @(posedge clock);
        #2;
        check("scoreboard_drained", 0, sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/toggle_counter.md
Name: toggle_counter

Overview:
Parametrised WIDTH-bit synchronous counter built from per-bit toggle cells, each with a true and complemented output.
- Features: up/down counting, programmable modulus, wrap or saturate mode, synchronous clear/load, registered terminal-count pulse.
- Used in the RLE path as the run-length / symbol-position counter; generalises the single toggle flip-flop cell to a full counter.

Parameters:
WIDTH, 4, counter width in bits (>=2)
MAX_COUNT, 2**WIDTH-1, highest count value; modulus = MAX_COUNT+1; must satisfy 1 <= MAX_COUNT <= 2**WIDTH-1
SATURATE, 0, 0 = wrap at the boundaries, 1 = hold at the boundaries

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
enable  input  1  count one step this cycle
up_down  input  1  1 = count up, 0 = count down
clear  input  1  synchronous clear to 0
load  input  1  synchronous load of load_value
load_value  input  WIDTH  value to load
count  output  WIDTH  current count (registered)
count_n  output  WIDTH  bitwise complement of count (registered; never combinationally derived from count)
terminal  output  1  registered one-cycle pulse when a boundary is hit
at_max  output  1  combinational: count == MAX_COUNT
at_zero  output  1  combinational: count == 0

Behaviour:
- Reset: reset is asynchronous, active-high; clock is clock. While reset is high: count=0, count_n=all ones, terminal=0.
- Priority per rising edge: clear > load > enable.
  - If none of the three is asserted, the counter holds.
  - up_down is sampled only when enable is high.
- clear: count<=0, count_n<=~0, terminal<=0.
- load:
  - count<=load_value. If load_value > MAX_COUNT, count<=MAX_COUNT (clamp).
  - terminal<=0.
- enable, up, count<MAX_COUNT: count<=count+1.
- enable, up, count==MAX_COUNT:
  - SATURATE=0: count<=0, terminal<=1.
  - SATURATE=1: count holds, terminal<=1 on the first saturating step only, 0 while held.
- enable, down, count>0: count<=count-1.
- enable, down, count==0:
  - SATURATE=0: count<=MAX_COUNT, terminal<=1.
  - SATURATE=1: hold, terminal<=1 on the first step only.
- terminal is 0 in every cycle not listed above, so it is a single-cycle pulse.
- Toggle derivation:
  - When MAX_COUNT==2**WIDTH-1, bit i toggles when enable is high and all lower bits are 1 (up) or all lower bits are 0 (down).
  - Otherwise the boundary rules above override the toggle mask.
- Latency:
  - count, count_n and terminal update 1 cycle after the qualifying edge.
  - at_max and at_zero follow count with zero added latency.
- Reset deasserted mid-operation: the counter restarts from 0; no pending step is retained.
- Invariant: count_n == ~count on every cycle.

Optional Feature:
TOGGLE_COUNTER_GRAY_EN
- Defined:
  - Adds output port gray (WIDTH bits), a registered Gray code of the next count: gray <= next ^ (next>>1).
  - gray resets to 0 and updates in the same cycle as count.
- Undefined: the port and its register are absent; all other behaviour is identical.

Decomposition:
- Package toggle_counter_pkg:
  - Mode constants MODE_WRAP=0, MODE_SAT=1.
  - Direction constants DIR_DOWN=0, DIR_UP=1.
  - Function clamp_load(value, max).
- Sub-module tff_cell, instantiated WIDTH times:
  - Ports: clock, reset, toggle, sync_set_val, sync_set, q, q_n.
  - Asynchronous reset to q=0, q_n=1.
  - sync_set forces q to sync_set_val (used for clear, load and wrap); otherwise q toggles when toggle=1.
- The top level computes the toggle mask, the boundary overrides and terminal.

Test Plan:
- Reset while running (WIDTH=4, default MAX): assert reset mid-count at count=7 -> count=0, count_n=4'hF, terminal=0 immediately, without waiting for a clock edge.
- Up wrap (WIDTH=4, MAX_COUNT=9, SATURATE=0): enable, up, 10 edges from 0 -> count 1..9 then 0; terminal=1 only in the cycle count returns to 0.
- Down wrap (MAX_COUNT=9): load 0, then enable with down -> count=9, terminal pulses once; next step -> 8, terminal=0.
- Saturate (SATURATE=1, MAX_COUNT=9): count up 12 steps from 0 -> holds at 9; terminal high for exactly 1 cycle; at_max=1 from the 9th step onward.
- Priority and clamp (MAX_COUNT=9): clear=load=enable=1 with load_value=5 -> count=0. Then load=1, load_value=14 -> count=9, terminal=0.
- Gray option (TOGGLE_COUNTER_GRAY_EN, default MAX): step up 0..15 -> gray goes 0,1,3,2,6,...,8; exactly one bit changes per step, including 15->0.
